// File: rtl/defs_pkg.sv
// Shared MEM-stage definitions: load/store encodings, trap causes, FSM states and
// the size/alignment helpers used by the address path.
package defs_pkg;

  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LD  = 3'd3;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;
  localparam logic [2:0] LWU = 3'd6;

  localparam logic [2:0] SB  = 3'd0;
  localparam logic [2:0] SH  = 3'd1;
  localparam logic [2:0] SW  = 3'd2;
  localparam logic [2:0] SD  = 3'd3;

  localparam logic [3:0] LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] LOAD_FAULT       = 4'd5;
  localparam logic [3:0] STORE_MISALIGNED = 4'd6;
  localparam logic [3:0] STORE_FAULT      = 4'd7;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  // Byte-enable pattern for an access of the given size, before lane shifting.
  function automatic logic [7:0] size_mask(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

  // Unknown encodings, and doublewords on a 32-bit datapath, count as misaligned.
  function automatic logic access_aligned(input logic [2:0] f3, input logic [2:0] addr_lo,
                                          input logic dw_legal);
    case (f3)
      LB, LBU: access_aligned = 1'b1;
      LH, LHU: access_aligned = (addr_lo[0] == 1'b0);
      LW, LWU: access_aligned = (addr_lo[1:0] == 2'b00);
      LD:      access_aligned = dw_legal & (addr_lo == 3'b000);
      default: access_aligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/ack bus between the MEM stage (master) and the memory (slave).
interface mem_stage_if #(
  parameter int unsigned XLEN = 64
);
  localparam int unsigned STRBW = XLEN / 8;

  logic             dmem_req;
  logic             dmem_we;
  logic [XLEN-1:0]  dmem_addr;
  logic [XLEN-1:0]  dmem_wdata;
  logic [STRBW-1:0] dmem_wstrb;
  logic [XLEN-1:0]  dmem_rdata;
  logic             dmem_ack;
  logic             dmem_err;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_rdata, dmem_ack, dmem_err
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_rdata, dmem_ack, dmem_err
  );
endinterface

// File: rtl/mem_stage_load_align.sv
// Load data alignment: moves the addressed bytes to lane 0 and sign/zero extends
// them according to the load encoding.
module load_align
  import defs_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0]            rdata,
  input  logic [$clog2(XLEN/8)-1:0]  offset,
  input  logic [2:0]                 funct3,
  output logic [XLEN-1:0]            load_data_c
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (funct3)
      LB:      load_data_c = XLEN'($signed(shifted[7:0]));
      LH:      load_data_c = XLEN'($signed(shifted[15:0]));
      LW:      load_data_c = XLEN'($signed(shifted[31:0]));
      LBU:     load_data_c = XLEN'(shifted[7:0]);
      LHU:     load_data_c = XLEN'(shifted[15:0]);
      LWU:     load_data_c = XLEN'(shifted[31:0]);
      default: load_data_c = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues loads/stores on the req/ack data bus and registers
// results toward writeback. Optional bus-fault traps: define DMEM_ACCESS_FAULT_EN.
module mem_stage
  import defs_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] pc_in,
  input  logic [4:0]      rd,
  input  logic [2:0]      funct3,
  input  logic            reg_write_enable,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            trap_in,
  input  logic [3:0]      trap_cause_in,
  input  logic            flush,
  mem_stage_if.master     dmem,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      rd_out,
  output logic            reg_write_enable_out,
  output logic [XLEN-1:0] pc_out,
  output logic            trap_out,
  output logic [3:0]      trap_cause_out,
  output logic            stall_req
);

  localparam int unsigned STRBW = XLEN / 8;
  localparam int unsigned OFFW  = $clog2(STRBW);

  mem_state_t       state_q;
  logic             req_q, we_q, flush_q, rwe_q;
  logic [XLEN-1:0]  addr_q, wdata_q, pc_q;
  logic [STRBW-1:0] wstrb_q;
  logic [2:0]       funct3_q;
  logic [OFFW-1:0]  offset_q;
  logic [4:0]       rd_q;

  logic             mem_op_c, aligned_c, fault_c;
  logic [OFFW-1:0]  offset_d;
  logic [XLEN-1:0]  addr_d, wdata_d, load_data_c;
  logic [STRBW-1:0] wstrb_d;

  assign mem_op_c  = (mem_read | mem_write) & ~trap_in & ~flush;
  assign aligned_c = access_aligned(funct3, alu_result[2:0], XLEN == 64);
  assign offset_d  = alu_result[OFFW-1:0];
  assign addr_d    = {alu_result[XLEN-1:OFFW], {OFFW{1'b0}}};
  assign wdata_d   = rs2_data << {offset_d, 3'b000};
  assign wstrb_d   = STRBW'(size_mask(funct3)) << offset_d;

  // Stall covers the issuing cycle and every ACCESS cycle up to (not including) the ack.
  assign stall_req = (state_q == IDLE) ? (mem_op_c & aligned_c) : ~dmem.dmem_ack;

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_wstrb = wstrb_q;

`ifdef DMEM_ACCESS_FAULT_EN
  assign fault_c = dmem.dmem_err;
`else
  logic unused_dmem_err;
  assign unused_dmem_err = dmem.dmem_err;
  assign fault_c         = 1'b0;
`endif

  load_align #(.XLEN(XLEN)) u_load_align (
    .rdata       (dmem.dmem_rdata),
    .offset      (offset_q),
    .funct3      (funct3_q),
    .load_data_c (load_data_c)
  );

  // Output registers default to a bubble each cycle; the branches below override.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q              <= IDLE;
      req_q                <= 1'b0;
      we_q                 <= 1'b0;
      flush_q              <= 1'b0;
      rwe_q                <= 1'b0;
      addr_q               <= '0;
      wdata_q              <= '0;
      pc_q                 <= '0;
      wstrb_q              <= '0;
      funct3_q             <= '0;
      offset_q             <= '0;
      rd_q                 <= '0;
      wb_data              <= '0;
      rd_out               <= '0;
      reg_write_enable_out <= 1'b0;
      pc_out               <= '0;
      trap_out             <= 1'b0;
      trap_cause_out       <= '0;
    end else begin
      wb_data              <= '0;
      rd_out               <= '0;
      reg_write_enable_out <= 1'b0;
      pc_out               <= '0;
      trap_out             <= 1'b0;
      trap_cause_out       <= '0;
      case (state_q)
        IDLE: begin
          if (flush) begin
            // bubble
          end else if (!mem_op_c) begin
            wb_data              <= alu_result;
            rd_out               <= rd;
            reg_write_enable_out <= reg_write_enable;
            pc_out               <= pc_in;
            trap_out             <= trap_in;
            trap_cause_out       <= trap_cause_in;
          end else if (aligned_c) begin
            state_q  <= ACCESS;
            req_q    <= 1'b1;
            we_q     <= ~mem_read;
            flush_q  <= 1'b0;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            funct3_q <= funct3;
            offset_q <= offset_d;
            rd_q     <= rd;
            pc_q     <= pc_in;
            rwe_q    <= reg_write_enable;
          end else begin
            wb_data        <= alu_result;
            rd_out         <= rd;
            pc_out         <= pc_in;
            trap_out       <= 1'b1;
            trap_cause_out <= mem_read ? LOAD_MISALIGNED : STORE_MISALIGNED;
          end
        end
        ACCESS: begin
          if (flush) flush_q <= 1'b1;
          if (dmem.dmem_ack) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            flush_q <= 1'b0;
            // A flush seen at any point during the access turns the result into a bubble.
            if (!(flush_q || flush)) begin
              rd_out <= rd_q;
              pc_out <= pc_q;
              if (fault_c) begin
                trap_out       <= 1'b1;
                trap_cause_out <= we_q ? STORE_FAULT : LOAD_FAULT;
              end else if (!we_q) begin
                wb_data              <= load_data_c;
                reg_write_enable_out <= rwe_q;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage (XLEN=64) against a byte-level
// reference model of the load/store rules.
module tb_mem_stage;
  import defs_pkg::*;

  localparam int unsigned XLEN = 64;
`ifdef DMEM_ACCESS_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic [63:0] alu_result, rs2_data, pc_in;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic        reg_write_enable, mem_read, mem_write, trap_in, flush;
  logic [3:0]  trap_cause_in;
  logic [63:0] wb_data, pc_out;
  logic [4:0]  rd_out;
  logic        reg_write_enable_out, trap_out, stall_req;
  logic [3:0]  trap_cause_out;

  int total = 0;
  int bad   = 0;
  bit          have_nop = 1'b0;
  logic [63:0] nop_alu;

  mem_stage_if #(.XLEN(XLEN)) dmem_bus ();

  mem_stage #(.XLEN(XLEN)) dut (
    .clk                  (clk),
    .resetn               (resetn),
    .alu_result           (alu_result),
    .rs2_data             (rs2_data),
    .pc_in                (pc_in),
    .rd                   (rd),
    .funct3               (funct3),
    .reg_write_enable     (reg_write_enable),
    .mem_read             (mem_read),
    .mem_write            (mem_write),
    .trap_in              (trap_in),
    .trap_cause_in        (trap_cause_in),
    .flush                (flush),
    .dmem                 (dmem_bus),
    .wb_data              (wb_data),
    .rd_out               (rd_out),
    .reg_write_enable_out (reg_write_enable_out),
    .pc_out               (pc_out),
    .trap_out             (trap_out),
    .trap_cause_out       (trap_cause_out),
    .stall_req            (stall_req)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: access size in bytes, 0 for an illegal encoding.
  function automatic int unsigned acc_bytes(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2, 3'd6: return 4;
      3'd3:       return 8;
      default:    return 0;
    endcase
  endfunction

  function automatic bit misaligned(input logic [2:0] f3, input logic [63:0] addr);
    int unsigned n = acc_bytes(f3);
    if (n == 0) return 1'b1;
    if (n == 8 && XLEN != 64) return 1'b1;
    return (int'(addr[2:0]) % n) != 0;
  endfunction

  function automatic logic [63:0] exp_load(input logic [63:0] rdat, input logic [2:0] off,
                                           input logic [2:0] f3);
    int unsigned n = acc_bytes(f3);
    logic [63:0] v = '0;
    for (int i = 0; i < 8; i++)
      if (i < n && int'(off) + i < 8) v[8*i +: 8] = rdat[8*(int'(off) + i) +: 8];
    if (f3 < 3'd4 && n < 8 && v[8*n - 1])
      for (int i = 0; i < 8; i++) if (i >= n) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [7:0] exp_wstrb(input logic [2:0] off, input int unsigned n);
    logic [7:0] s = '0;
    for (int i = 0; i < 8; i++) if (i < n && int'(off) + i < 8) s[int'(off) + i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] exp_wdata(input logic [63:0] rs2, input logic [2:0] off);
    logic [63:0] d = '0;
    for (int i = 0; i < 8; i++) if (int'(off) + i < 8) d[8*(int'(off) + i) +: 8] = rs2[8*i +: 8];
    return d;
  endfunction

  // One instruction through the stage, followed by a non-memory filler cycle.
  task automatic run_op(input bit ld, input bit st, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] rs2, input logic [63:0] rdat, input int delay,
                        input bit err, input bit trp, input bit fl_idle, input int fl_at);
    logic [63:0] pc_v    = {$urandom, $urandom};
    logic [4:0]  rd_v    = 5'($urandom);
    logic        rwe_v   = 1'($urandom);
    logic [3:0]  cause_v = 4'($urandom);
    int unsigned n       = acc_bytes(f3);
    logic [2:0]  off     = addr[2:0];
    bit is_mem, bad_al, go, flushed, chk_wb, chk_rdpc;
    logic [63:0] e_wb;
    logic        e_rwe, e_trap;
    logic [3:0]  e_cause;

    is_mem  = (ld || st) && !trp && !fl_idle;
    bad_al  = misaligned(f3, addr);
    go      = is_mem && !bad_al;
    flushed = 1'b0;

    alu_result = addr;  rs2_data = rs2;  pc_in = pc_v;  rd = rd_v;  funct3 = f3;
    reg_write_enable = rwe_v;  mem_read = ld;  mem_write = st;
    trap_in = trp;  trap_cause_in = cause_v;  flush = fl_idle;

    @(negedge clk);
    check("idle_stall", 64'(stall_req), 64'(go));
    check("idle_req", 64'(dmem_bus.dmem_req), 64'd0);
    if (have_nop) check("nop_wb", wb_data, nop_alu);
    @(posedge clk); #1;
    flush = 1'b0;

    if (go) begin
      for (int c = 0; c <= delay; c++) begin
        dmem_bus.dmem_ack   = (c == delay);
        dmem_bus.dmem_rdata = (c == delay) ? rdat : {$urandom, $urandom};
        dmem_bus.dmem_err   = (c == delay) && err;
        flush               = (c == fl_at);
        if (c == fl_at) flushed = 1'b1;
        @(negedge clk);
        check("acc_req",   64'(dmem_bus.dmem_req), 64'd1);
        check("acc_we",    64'(dmem_bus.dmem_we), 64'(st));
        check("acc_addr",  dmem_bus.dmem_addr, addr & ~64'h7);
        check("acc_wdata", dmem_bus.dmem_wdata, exp_wdata(rs2, off));
        check("acc_wstrb", 64'(dmem_bus.dmem_wstrb), 64'(exp_wstrb(off, n)));
        check("acc_stall", 64'(stall_req), 64'(c != delay));
        @(posedge clk); #1;
        dmem_bus.dmem_ack = 1'b0;
        dmem_bus.dmem_err = 1'b0;
        flush             = 1'b0;
      end
    end

    chk_wb = 1'b1;  chk_rdpc = 1'b1;
    e_wb = '0;  e_rwe = 1'b0;  e_trap = 1'b0;  e_cause = 4'd0;
    if (fl_idle) begin
      chk_wb = 1'b0;  chk_rdpc = 1'b0;
    end else if (!is_mem) begin
      e_wb = addr;  e_rwe = rwe_v;  e_trap = trp;  e_cause = cause_v;
    end else if (bad_al) begin
      chk_wb = 1'b0;  e_trap = 1'b1;  e_cause = ld ? 4'd4 : 4'd6;
    end else if (flushed) begin
      chk_wb = 1'b0;  chk_rdpc = 1'b0;
    end else if (err && FAULT_EN) begin
      chk_wb = 1'b0;  e_trap = 1'b1;  e_cause = ld ? 4'd5 : 4'd7;
    end else if (!st) begin
      e_wb = exp_load(rdat, off, f3);  e_rwe = rwe_v;
    end

    nop_alu = {$urandom, $urandom};
    alu_result = nop_alu;  mem_read = 1'b0;  mem_write = 1'b0;  trap_in = 1'b0;
    reg_write_enable = 1'b0;  flush = 1'b0;  funct3 = 3'($urandom);
    dmem_bus.dmem_ack   = 1'($urandom);
    dmem_bus.dmem_rdata = {$urandom, $urandom};

    @(negedge clk);
    if (chk_wb) check("wb_data", wb_data, e_wb);
    check("rwe_out",   64'(reg_write_enable_out), 64'(e_rwe));
    check("trap_out",  64'(trap_out), 64'(e_trap));
    check("cause_out", 64'(trap_cause_out), 64'(e_cause));
    if (chk_rdpc) begin
      check("rd_out", 64'(rd_out), 64'(rd_v));
      check("pc_out", pc_out, pc_v);
    end
    check("post_req",   64'(dmem_bus.dmem_req), 64'd0);
    check("post_stall", 64'(stall_req), 64'd0);
    @(posedge clk); #1;
    dmem_bus.dmem_ack = 1'b0;
    have_nop = 1'b1;
  endtask

  // Asynchronous reset in the middle of an access must drop the request at once.
  task automatic reset_mid_access();
    alu_result = 64'h3000;  funct3 = LW;  mem_read = 1'b1;  mem_write = 1'b0;
    trap_in = 1'b0;  flush = 1'b0;  reg_write_enable = 1'b1;
    @(posedge clk); #1;
    mem_read = 1'b0;
    @(negedge clk);
    check("rst_pre_req", 64'(dmem_bus.dmem_req), 64'd1);
    #2 resetn = 1'b0;
    #1;
    check("rst_req",   64'(dmem_bus.dmem_req), 64'd0);
    check("rst_stall", 64'(stall_req), 64'd0);
    check("rst_rwe",   64'(reg_write_enable_out), 64'd0);
    #1 resetn = 1'b1;
    @(posedge clk); #1;
    have_nop = 1'b0;
  endtask

  initial begin
    bit ld, st, fl_idle, err;
    logic [2:0]  f3;
    logic [63:0] addr;
    int k, delay, fl_at;
    int unsigned n;

    resetn = 1'b0;
    alu_result = '0;  rs2_data = '0;  pc_in = '0;  rd = '0;  funct3 = '0;
    reg_write_enable = 1'b0;  mem_read = 1'b0;  mem_write = 1'b0;
    trap_in = 1'b0;  trap_cause_in = '0;  flush = 1'b0;
    dmem_bus.dmem_ack = 1'b0;  dmem_bus.dmem_err = 1'b0;  dmem_bus.dmem_rdata = '0;

    #12;
    check("rst_wb",    wb_data, 64'd0);
    check("rst_rd",    64'(rd_out), 64'd0);
    check("rst_rwe0",  64'(reg_write_enable_out), 64'd0);
    check("rst_pc",    pc_out, 64'd0);
    check("rst_trap",  64'(trap_out), 64'd0);
    check("rst_cause", 64'(trap_cause_out), 64'd0);
    check("rst_req0",  64'(dmem_bus.dmem_req), 64'd0);
    check("rst_stall0", 64'(stall_req), 64'd0);
    #1 resetn = 1'b1;
    @(posedge clk); #1;

    run_op(1, 0, LW,  64'h1004, 64'h0, 64'hFFFFFFFE_00000000, 0, 0, 0, 0, -1);
    run_op(1, 0, LWU, 64'h1004, 64'h0, 64'hFFFFFFFE_00000000, 0, 0, 0, 0, -1);
    run_op(0, 1, SB,  64'h1003, 64'hAB, 64'h0, 0, 0, 0, 0, -1);
    run_op(1, 0, LH,  64'h1001, 64'h0, 64'h0, 0, 0, 0, 0, -1);
    run_op(0, 1, SD,  64'h2000, 64'h0123_4567_89AB_CDEF, 64'h0, 3, 0, 0, 0, -1);
    run_op(1, 0, LW,  64'h1008, 64'h0, 64'h8000_0000_8000_0000, 3, 0, 0, 0, 1);
    run_op(1, 0, LD,  64'h1010, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 1, 1, 0, 0, -1);
    run_op(0, 1, SW,  64'h1013, 64'h55, 64'h0, 0, 0, 0, 0, -1);
    run_op(1, 0, LW,  64'h1020, 64'h0, 64'h0, 0, 0, 1, 0, -1);
    run_op(1, 0, LB,  64'h1021, 64'h0, 64'h0, 0, 0, 0, 1, -1);
    run_op(1, 0, 3'd7, 64'h1000, 64'h0, 64'h0, 0, 0, 0, 0, -1);
    reset_mid_access();

    for (int i = 0; i < 400; i++) begin
      k  = $urandom_range(0, 9);
      ld = (k >= 2 && k < 6) || k == 9;
      st = (k >= 6 && k < 9);
      f3 = st ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      addr = {$urandom, $urandom};
      n = acc_bytes(f3);
      if (n != 0 && $urandom_range(0, 2) != 0) addr[2:0] = addr[2:0] & ~3'(n - 1);
      fl_idle = ($urandom_range(0, 11) == 0);
      fl_at   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
      delay   = int'($urandom_range(0, 3));
      err     = ($urandom_range(0, 5) == 0);
      run_op(ld, st, f3, addr, {$urandom, $urandom}, {$urandom, $urandom},
             delay, err, (k == 9), fl_idle, fl_at);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
